// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  // Grant index width; a single requester still needs one bit.
  function automatic int unsigned gnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bcnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit strictly after rr_ptr_i,
// searching upward with wrap-around.
module rr_pick #(
  parameter int unsigned NReq = 4,
  parameter int unsigned GntW = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [GntW-1:0] rr_ptr_i,
  output logic [GntW-1:0] winner_o,
  output logic            any_o
);

  logic [GntW-1:0] idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NReq; k++) begin
      idx = GntW'((32'(rr_ptr_i) + k) % NReq);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ valid/ready requesters.
// Define FIFO_WR_ARB_STATS_EN to add the stall_cnt statistics counter and stats_clr.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    w_en,
  output logic [DSIZE-1:0]        wdata,
  input  logic                    wfull,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                    stats_clr,
  output logic [15:0]             stall_cnt,
`endif
  output logic [gnt_w(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int unsigned GntW  = gnt_w(NREQ);
  localparam int unsigned BcntW = bcnt_w(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [GntW-1:0]  grant_q, grant_d;
  logic [GntW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BcntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [GntW-1:0]  winner;
  logic             any_req;
  logic             accept;
  logic             release_grant;
  logic [DSIZE-1:0] req_words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_words[i] = req_data[i*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NReq (NREQ),
    .GntW (GntW)
  ) u_rr_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign busy          = (state_q == StBurst);
  assign grant_id      = grant_q;
  assign accept        = busy & req_valid[grant_q] & ~wfull;
  // The last beat of a burst is recognised on the word that would bring the count to MAX_BURST.
  assign release_grant = accept &
                         (req_last[grant_q] | (beat_cnt_q == BcntW'(MAX_BURST - 1)));

  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grant_q] = ~wfull;
    end
    w_en  = accept;
    wdata = accept ? req_words[grant_q] : '0;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (release_grant) begin
          state_d    = StIdle;
          rr_ptr_d   = grant_q;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + BcntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= GntW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
    end else if (busy && req_valid[grant_q] && wfull && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
